ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Background scrubber for a 52-bit data + 7-bit parity SEC-DED protected SRAM.
- Walks the array one word at a time on a programmable interval and checks each word through a single time-shared ECC instance.
- Writes back corrected data and regenerated parity on single-bit errors; logs double-bit errors.
- Sits beside the FIFO/SRAM macro and yields the memory port to functional traffic whenever that traffic requests it.

Parameters:
- ADDR_WIDTH, 6, memory address width.
- DEPTH, 64, number of words scrubbed per pass; last scrubbed address is DEPTH-1, and DEPTH <= 2^ADDR_WIDTH.
- CNT_WIDTH, 16, width of the interval counter and the error counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scrub_en  input  1  enables scrubbing
- scrub_interval  input  CNT_WIDTH  idle cycles between word scrubs
- clr_cnt  input  1  synchronous clear of counters and the dbit flag
- func_req  input  1  functional access owns the memory port this cycle
- mem_ren  output  1  scrub read strobe
- mem_wen  output  1  scrub write strobe
- mem_addr  output  ADDR_WIDTH  scrub address
- mem_wdata  output  52  writeback data
- mem_wparity  output  7  writeback parity
- mem_rdata  input  52  read data, valid 1 cycle after mem_ren
- mem_rparity  input  7  read parity, valid 1 cycle after mem_ren
- sbit_cnt  output  CNT_WIDTH  corrected-error count, saturating
- dbit_cnt  output  CNT_WIDTH  uncorrectable-error count, saturating
- dbit_flag  output  1  sticky: a double-bit error has been seen
- dbit_addr  output  ADDR_WIDTH  address of the most recent double-bit error
- pass_done  output  1  one-cycle pulse when address DEPTH-1 completes
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs and registers are 0, the FSM is in IDLE, and the scrub address is 0. Reset mid-operation abandons the current word with no write.
- States: IDLE, RD, CAP, CHK, WB, NEXT.
- IDLE, scrub_en=1:
  - Interval counter counts down to 0, then the FSM moves to RD.
  - The counter reloads from scrub_interval on entry to IDLE.
  - scrub_interval=0 gives back-to-back words, with 1 IDLE cycle between them.
- IDLE, scrub_en=0: the counter holds at its reload value.
- RD:
  - If func_req=0: mem_ren=1, mem_addr = scrub address, next state CAP.
  - If func_req=1: mem_ren=0 and the FSM stays in RD.
- CAP: mem_rdata/mem_rparity are registered into word_q/par_q.
- CHK: the ECC instance is driven with word_q/par_q and bypass=0.
  - sbit=1: corrected data is registered into corr_q, sbit_cnt increments, next state WB. This includes parity-only errors, where corr_q equals word_q.
  - dbit=1: dbit_cnt increments, dbit_flag is set, dbit_addr is loaded with the scrub address, next state NEXT. No write.
  - Clean word: next state NEXT.
- WB: the ECC input is muxed to corr_q, and the encoder output supplies mem_wparity.
  - If func_req=0: mem_wen=1, mem_wdata=corr_q, next state NEXT.
  - If func_req=1: the FSM stalls in WB with mem_wen=0.
- NEXT:
  - Address increments, wrapping from DEPTH-1 to 0.
  - pass_done pulses when wrapping.
  - Next state IDLE.
- Port ownership: mem_ren and mem_wen are never 1 in a cycle where func_req=1. mem_ren and mem_wen are never both 1.
- scrub_en dropping mid-word: the current word completes, including WB; scrubbing stops in IDLE.
- Latency, clean word, no stalls: IDLE exit to IDLE return is 4 cycles.
- Counters saturate at all-ones. clr_cnt wins over a simultaneous increment and clears sbit_cnt, dbit_cnt and dbit_flag. dbit_addr is not cleared by clr_cnt.

Decomposition:
- Shared package holds:
  - ECC widths: DATA_W=52, PAR_W=7.
  - The FSM state enum with 3-bit encoding.
- Sub-module: one ecc_52_top instance, bypass tied 0, input muxed between par/word_q (CHK) and corr_q (WB).

Test Plan:
- All words clean, scrub_interval=3, DEPTH=64 -> no mem_wen, both counters 0, pass_done pulses once every 64 words, 7 cycles per word.
- Word 5 preloaded with data bit 17 flipped -> exactly one write to address 5 with corrected data and correct parity; sbit_cnt=1; rescan of word 5 is clean.
- Word 9 with two data bits flipped -> no write; dbit_cnt=1, dbit_flag=1, dbit_addr=9; clr_cnt then gives counters 0 and dbit_flag 0, with dbit_addr still 9.
- Word 3 with parity bit 6 flipped -> sbit_cnt=1; writeback has data unchanged and parity regenerated.
- func_req held high for 10 cycles during RD, then during WB -> no mem_ren/mem_wen while high; the access completes 1 cycle after func_req falls and the data is correct.
- rst_n asserted in WB, and scrub_en deasserted in CHK of an sbit word -> after reset all outputs are 0 and the address is 0; without reset the WB completes, the FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/ecc_scrub_ctrl_pkg.sv
// Shared definitions for the ECC scrubber: code widths, FSM states and the
// SEC-DED bit-placement helper used by the (59,52) encoder/decoder.
package ecc_scrub_ctrl_pkg;

    localparam int DATA_W   = 52;  // protected data bits per word
    localparam int PAR_W    = 7;   // 6 Hamming check bits + 1 overall parity
    localparam int HAM_W    = 6;   // Hamming check bits / syndrome width
    localparam int CODE_MAX = 58;  // highest Hamming codeword position in use

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        CHK  = 3'd3,
        WB   = 3'd4,
        NEXT = 3'd5
    } state_t;

    // Codeword position of data bit idx. Check bits sit at the power-of-two
    // positions 1,2,4,...,32; data bits fill the remaining positions 3..58
    // in ascending order, so a single-bit syndrome names the failing position.
    function automatic logic [HAM_W-1:0] data_pos(input int idx);
        int cnt;
        data_pos = '0;
        cnt      = 0;
        for (int p = 3; p <= CODE_MAX; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) data_pos = HAM_W'(p);
                cnt++;
            end
        end
    endfunction

endpackage

// File: rtl/ecc_scrub_ctrl_ecc.sv
// Combinational SEC-DED (59,52) encoder/decoder. parity_out is always the
// freshly encoded parity of data_in; data_out is data_in with a single-bit
// data error corrected. bypass passes data through and suppresses both flags.
module ecc_52_top
    import ecc_scrub_ctrl_pkg::*;
(
    input  logic              bypass,
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAR_W-1:0]  parity_in,
    output logic [DATA_W-1:0] data_out,
    output logic [PAR_W-1:0]  parity_out,
    output logic              sbit,
    output logic              dbit
);

    logic [HAM_W-1:0] ham;
    logic [HAM_W-1:0] syndrome;
    logic             overall_err;
    logic             single_err;
    logic             double_err;

    // Recompute the Hamming check bits: every set data bit folds in its position.
    always_comb begin
        // NOTE: combinational blocks assign a default first so no latch is inferred.
        ham = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_in[i]) ham = ham ^ data_pos(i);
        end
    end

    assign parity_out  = {(^data_in) ^ (^ham), ham};
    assign syndrome    = ham ^ parity_in[HAM_W-1:0];
    assign overall_err = (^data_in) ^ (^parity_in);

    // Odd overall parity means one flipped bit, unless the syndrome points past
    // the end of the codeword, which only a multi-bit error can produce.
    assign single_err = overall_err && (syndrome <= HAM_W'(CODE_MAX));
    assign double_err = (!overall_err && (syndrome != '0)) ||
                        (overall_err && (syndrome > HAM_W'(CODE_MAX)));

    assign sbit = !bypass && single_err;
    assign dbit = !bypass && double_err;

    // Flip the data bit the syndrome names; check-bit errors leave data untouched.
    always_comb begin
        data_out = data_in;
        if (sbit) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (syndrome == data_pos(i)) data_out[i] = ~data_in[i];
            end
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: walks the SRAM one word per interval, checks each word
// through a shared SEC-DED instance, writes back single-bit corrections and
// logs double-bit errors. Always yields the memory port to functional traffic.
module ecc_scrub_ctrl
    import ecc_scrub_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    input  logic [CNT_WIDTH-1:0]  scrub_interval,
    input  logic                  clr_cnt,
    input  logic                  func_req,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [PAR_W-1:0]      mem_wparity,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic [PAR_W-1:0]      mem_rparity,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic                  dbit_flag,
    output logic [ADDR_WIDTH-1:0] dbit_addr,
    output logic                  pass_done,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  interval_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     word_q;
    logic [PAR_W-1:0]      par_q;
    logic [DATA_W-1:0]     corr_q;

    logic [DATA_W-1:0]     ecc_din;
    logic [PAR_W-1:0]      ecc_pin;
    logic [DATA_W-1:0]     ecc_dout;
    logic [PAR_W-1:0]      ecc_pout;
    logic                  ecc_sbit;
    logic                  ecc_dbit;

    // In WB the encoder regenerates parity from the corrected word; otherwise
    // the decoder checks the captured word against its stored parity.
    assign ecc_din = (state == WB) ? corr_q : word_q;
    assign ecc_pin = (state == WB) ? '0     : par_q;

    ecc_52_top u_ecc (
        .bypass     (1'b0),
        .data_in    (ecc_din),
        .parity_in  (ecc_pin),
        .data_out   (ecc_dout),
        .parity_out (ecc_pout),
        .sbit       (ecc_sbit),
        .dbit       (ecc_dbit)
    );

    // Strobes are gated by func_req in the same cycle so the scrubber can never
    // collide with functional traffic on the shared port.
    assign mem_ren     = (state == RD) && !func_req;
    assign mem_wen     = (state == WB) && !func_req;
    assign mem_addr    = addr_q;
    assign mem_wdata   = corr_q;
    assign mem_wparity = ecc_pout;
    assign busy        = (state != IDLE);

    // Scrub FSM plus the address walker, capture registers and error log.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            interval_q <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            par_q      <= '0;
            corr_q     <= '0;
            sbit_cnt   <= '0;
            dbit_cnt   <= '0;
            dbit_flag  <= 1'b0;
            dbit_addr  <= '0;
            pass_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pass_done <= 1'b0;
            if (clr_cnt) begin
                sbit_cnt  <= '0;
                dbit_cnt  <= '0;
                dbit_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Leaving at 1 (not 0) makes the IDLE dwell equal the
                    // interval, with a floor of the single mandatory IDLE cycle.
                    if (scrub_en) begin
                        if (interval_q <= CNT_ONE) state <= RD;
                        else                      interval_q <= interval_q - CNT_ONE;
                    end
                end
                RD: begin
                    if (!func_req) state <= CAP;
                end
                CAP: begin
                    word_q <= mem_rdata;
                    par_q  <= mem_rparity;
                    state  <= CHK;
                end
                CHK: begin
                    if (ecc_sbit) begin
                        corr_q <= ecc_dout;
                        if (!clr_cnt && (sbit_cnt != '1)) sbit_cnt <= sbit_cnt + CNT_ONE;
                        state <= WB;
                    end else if (ecc_dbit) begin
                        if (!clr_cnt) begin
                            if (dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_ONE;
                            dbit_flag <= 1'b1;
                        end
                        dbit_addr <= addr_q;
                        state     <= NEXT;
                    end else begin
                        state <= NEXT;
                    end
                end
                WB: begin
                    if (!func_req) state <= NEXT;
                end
                NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q    <= '0;
                        pass_done <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                    interval_q <= scrub_interval;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: a behavioural SRAM with a
// preload path, a table of single-word error cases scrubbed over two passes,
// and directed sequences for timing, stalls, reset and counter clearing.
module tb_ecc_scrub_ctrl;

    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scrub_en;
    logic [CW-1:0] scrub_interval;
    logic          clr_cnt;
    logic          func_req;
    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [51:0]   mem_wdata;
    logic [6:0]    mem_wparity;
    logic [51:0]   mem_rdata   = '0;
    logic [6:0]    mem_rparity = '0;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic          dbit_flag;
    logic [AW-1:0] dbit_addr;
    logic          pass_done;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [51:0]   mem_d  [DEPTH];
    logic [6:0]    mem_p  [DEPTH];
    logic [51:0]   init_d [DEPTH];
    logic [6:0]    init_p [DEPTH];
    logic [51:0]   gold_d [DEPTH];
    logic [6:0]    gold_p [DEPTH];
    logic          preload    = 1'b0;
    int            wr_count   = 0;
    int            ren_count  = 0;
    int            viol_count = 0;
    logic [AW-1:0] last_waddr = '0;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scrub_en       (scrub_en),
        .scrub_interval (scrub_interval),
        .clr_cnt        (clr_cnt),
        .func_req       (func_req),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wparity    (mem_wparity),
        .mem_rdata      (mem_rdata),
        .mem_rparity    (mem_rparity),
        .sbit_cnt       (sbit_cnt),
        .dbit_cnt       (dbit_cnt),
        .dbit_flag      (dbit_flag),
        .dbit_addr      (dbit_addr),
        .pass_done      (pass_done),
        .busy           (busy)
    );

    // SRAM model: 1-cycle read latency, write on strobe, port-ownership monitor.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= init_d[i];
                mem_p[i] <= init_p[i];
            end
        end else begin
            if (mem_ren) begin
                mem_rdata   <= mem_d[mem_addr];
                mem_rparity <= mem_p[mem_addr];
                ren_count   <= ren_count + 1;
            end
            if (mem_wen) begin
                mem_d[mem_addr] <= mem_wdata;
                mem_p[mem_addr] <= mem_wparity;
                wr_count        <= wr_count + 1;
                last_waddr      <= mem_addr;
            end
        end
        if ((func_req && (mem_ren || mem_wen)) || (mem_ren && mem_wen))
            viol_count <= viol_count + 1;
    end

    // Reference encoder: build the 64-position codeword explicitly, then each
    // check bit i is the parity of every position whose index has bit i set.
    function automatic logic [6:0] ref_enc(input logic [51:0] d);
        logic [63:0] c;
        logic [6:0]  p;
        int          k;
        c = '0;
        p = '0;
        k = 0;
        for (int pos = 1; pos < 64; pos++) begin
            if (((pos & (pos - 1)) != 0) && (k < 52)) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            for (int pos = 1; pos < 64; pos++) begin
                if (pos[i]) p[i] = p[i] ^ c[pos];
            end
        end
        p[6] = (^d) ^ (^p[5:0]);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fresh random contents with correct parity; all words start clean.
    task automatic make_clean();
        logic [63:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r         = {$urandom, $urandom};
            gold_d[i] = r[51:0];
            gold_p[i] = ref_enc(r[51:0]);
            init_d[i] = gold_d[i];
            init_p[i] = gold_p[i];
        end
    endtask

    task automatic inject(input int a, input logic [51:0] dflip, input logic [6:0] pflip);
        init_d[a] = gold_d[a] ^ dflip;
        init_p[a] = gold_p[a] ^ pflip;
    endtask

    // Reset the DUT and copy init_* into the SRAM while reset is held.
    task automatic do_reset();
        rst_n          = 1'b0;
        scrub_en       = 1'b0;
        clr_cnt        = 1'b0;
        func_req       = 1'b0;
        scrub_interval = '0;
        preload        = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Run until n pass_done pulses; scrub_en drops in the IDLE cycle of the last one.
    task automatic wait_pass(input int n, input int budget, input string name);
        int seen = 0;
        int cyc  = 0;
        while ((seen < n) && (cyc < budget)) begin
            tick();
            cyc++;
            if (pass_done) seen++;
        end
        scrub_en = 1'b0;
        check(name, seen, n);
    endtask

    typedef struct {
        int          addr;
        logic [51:0] dflip;
        logic [6:0]  pflip;
        int          exp_wr;
        int          exp_sbit;
        int          exp_dbit;
        logic        exp_flag;
        int          exp_daddr;
        logic        exp_fixed;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   wr0;
        int   ren0;
        int   cyc;
        int   passes;
        int   prev;
        int   period;
        int   rens;
        logic [51:0] exp_d;
        logic [6:0]  exp_p;

        rst_n          = 1'b0;
        scrub_en       = 1'b0;
        clr_cnt        = 1'b0;
        func_req       = 1'b0;
        scrub_interval = '0;

        //              addr  data flip                         par flip  wr sb db flag da fixed
        vecs[0] = '{    5, 52'(1) << 17,                     7'h00,    1, 1, 0, 1'b0, 0, 1'b1};
        vecs[1] = '{    9, (52'(1) << 3) | (52'(1) << 40),   7'h00,    0, 0, 2, 1'b1, 9, 1'b0};
        vecs[2] = '{    3, 52'(0),                           7'h40,    1, 1, 0, 1'b0, 0, 1'b1};
        vecs[3] = '{   63, 52'(1),                           7'h00,    1, 1, 0, 1'b0, 0, 1'b1};
        vecs[4] = '{    0, 52'(0),                           7'h01,    1, 1, 0, 1'b0, 0, 1'b1};
        vecs[5] = '{   20, 52'(1) << 51,                     7'h04,    0, 0, 2, 1'b1, 20, 1'b0};
        vecs[6] = '{   40, 52'(0),                           7'h00,    0, 0, 0, 1'b0, 0, 1'b1};

        // Reset state.
        make_clean();
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_sbit_cnt", sbit_cnt, 0);
        check("rst_dbit_cnt", dbit_cnt, 0);

        // Table: one faulty word, two full passes at interval 0.
        for (int k = 0; k < 7; k++) begin
            make_clean();
            inject(vecs[k].addr, vecs[k].dflip, vecs[k].pflip);
            do_reset();
            wr0      = wr_count;
            scrub_en = 1'b1;
            wait_pass(2, 2000, $sformatf("v%0d_passes", k));
            tick();
            exp_d = vecs[k].exp_fixed ? gold_d[vecs[k].addr] : (gold_d[vecs[k].addr] ^ vecs[k].dflip);
            exp_p = vecs[k].exp_fixed ? gold_p[vecs[k].addr] : (gold_p[vecs[k].addr] ^ vecs[k].pflip);
            check($sformatf("v%0d_writes", k), wr_count - wr0, vecs[k].exp_wr);
            check($sformatf("v%0d_sbit_cnt", k), sbit_cnt, vecs[k].exp_sbit);
            check($sformatf("v%0d_dbit_cnt", k), dbit_cnt, vecs[k].exp_dbit);
            check($sformatf("v%0d_dbit_flag", k), dbit_flag, vecs[k].exp_flag);
            check($sformatf("v%0d_dbit_addr", k), dbit_addr, vecs[k].exp_daddr);
            check($sformatf("v%0d_mem_data", k), mem_d[vecs[k].addr], exp_d);
            check($sformatf("v%0d_mem_par", k), mem_p[vecs[k].addr], exp_p);
            if (vecs[k].exp_wr > 0)
                check($sformatf("v%0d_wr_addr", k), last_waddr, vecs[k].addr);
        end

        // Clean array at interval 3: 7 cycles per word, 64 reads per pass, no writes.
        make_clean();
        do_reset();
        scrub_interval = 16'd3;
        scrub_en       = 1'b1;
        wr0    = wr_count;
        cyc    = 0;
        passes = 0;
        prev   = -1;
        period = 0;
        rens   = 0;
        while ((passes < 2) && (cyc < 2000)) begin
            tick();
            cyc++;
            if (mem_ren) begin
                if (prev >= 0) period = cyc - prev;
                prev = cyc;
                if (passes == 1) rens++;
            end
            if (pass_done) passes++;
        end
        scrub_en = 1'b0;
        check("clean_passes", passes, 2);
        check("clean_reads_per_pass", rens, 64);
        check("clean_word_period", period, 7);
        check("clean_writes", wr_count - wr0, 0);
        check("clean_sbit_cnt", sbit_cnt, 0);
        check("clean_dbit_cnt", dbit_cnt, 0);
        check("clean_wrap_addr", mem_addr, 0);
        tick();
        check("pass_done_width", pass_done, 0);

        // func_req stalls in RD and in WB; word 0 has data bit 10 flipped.
        make_clean();
        inject(0, 52'(1) << 10, 7'h00);
        do_reset();
        wr0            = wr_count;
        ren0           = ren_count;
        func_req       = 1'b1;
        scrub_en       = 1'b1;
        repeat (10) tick();
        check("rd_stall_busy", busy, 1);
        check("rd_stall_ren", mem_ren, 0);
        check("rd_stall_reads", ren_count - ren0, 0);
        func_req = 1'b0;
        #1;
        check("rd_release_ren", mem_ren, 1);
        check("rd_release_addr", mem_addr, 0);
        tick();
        tick();
        func_req = 1'b1;
        tick();
        check("wb_stall_wen", mem_wen, 0);
        repeat (9) tick();
        check("wb_stall_busy", busy, 1);
        check("wb_stall_wen_late", mem_wen, 0);
        check("wb_stall_writes", wr_count - wr0, 0);
        func_req = 1'b0;
        #1;
        check("wb_release_wen", mem_wen, 1);
        check("wb_wdata", mem_wdata, gold_d[0]);
        check("wb_wparity", mem_wparity, gold_p[0]);
        tick();
        scrub_en = 1'b0;
        check("wb_writes", wr_count - wr0, 1);
        check("wb_mem_data", mem_d[0], gold_d[0]);
        check("wb_mem_par", mem_p[0], gold_p[0]);
        check("wb_sbit_cnt", sbit_cnt, 1);

        // Reset while in WB abandons the write and clears everything.
        make_clean();
        inject(0, 52'(1) << 30, 7'h00);
        do_reset();
        wr0      = wr_count;
        scrub_en = 1'b1;
        repeat (4) tick();
        check("rstwb_in_wb", mem_wen, 1);
        rst_n = 1'b0;
        #1;
        check("rstwb_wen", mem_wen, 0);
        check("rstwb_ren", mem_ren, 0);
        check("rstwb_busy", busy, 0);
        check("rstwb_addr", mem_addr, 0);
        check("rstwb_sbit_cnt", sbit_cnt, 0);
        check("rstwb_flags", {dbit_cnt, dbit_flag, dbit_addr, pass_done}, 0);
        check("rstwb_wdata", {mem_wdata, mem_wparity}, 0);
        tick();
        tick();
        check("rstwb_writes", wr_count - wr0, 0);

        // scrub_en drops during CHK of an sbit word: WB still completes, then idle.
        do_reset();
        wr0      = wr_count;
        ren0     = ren_count;
        scrub_en = 1'b1;
        tick();
        tick();
        tick();
        scrub_en = 1'b0;
        tick();
        check("endrop_wb_wen", mem_wen, 1);
        tick();
        tick();
        check("endrop_idle", busy, 0);
        repeat (20) tick();
        check("endrop_stays_idle", busy, 0);
        check("endrop_reads", ren_count - ren0, 1);
        check("endrop_writes", wr_count - wr0, 1);
        check("endrop_mem_data", mem_d[0], gold_d[0]);
        check("endrop_addr", mem_addr, 1);

        // clr_cnt beats a simultaneous increment; dbit_addr survives clearing.
        make_clean();
        inject(9, (52'(1) << 3) | (52'(1) << 40), 7'h00);
        do_reset();
        clr_cnt  = 1'b1;
        scrub_en = 1'b1;
        wait_pass(1, 1000, "clr_pass1");
        check("clr_held_dbit_cnt", dbit_cnt, 0);
        check("clr_held_flag", dbit_flag, 0);
        check("clr_held_daddr", dbit_addr, 9);
        clr_cnt  = 1'b0;
        scrub_en = 1'b1;
        wait_pass(1, 1000, "clr_pass2");
        check("clr_pre_dbit_cnt", dbit_cnt, 1);
        check("clr_pre_flag", dbit_flag, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_dbit_cnt", dbit_cnt, 0);
        check("clr_sbit_cnt", sbit_cnt, 0);
        check("clr_flag", dbit_flag, 0);
        check("clr_daddr_kept", dbit_addr, 9);

        check("port_ownership", viol_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
